// File: rtl/pipelined_controller.sv
// Pipelined, condition-aware control unit: decodes in D and carries the control word through E/M/W.
// Optional `COND_LOGIC_EN enables ARM condition evaluation against the internal NZCV register.
module pipelined_controller #(
  parameter int ALUCTRL_W  = 3,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            OpD,
  input  logic [5:0]            FunctD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic [3:0]            CondD,
  input  logic [3:0]            ALUFlagsE,
  input  logic                  FlushE,
  output logic [1:0]            RegSrcD,
  output logic [1:0]            ImmSrcD,
  output logic                  ALUSrcE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic                  BranchTakenE,
  output logic                  MemtoRegE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  MemtoRegW,
  output logic                  RegWriteW,
  output logic                  PCSrcW,
  output logic [3:0]            FlagsQ
);

  typedef struct packed {
    logic                 reg_w;
    logic                 mem_w;
    logic                 mem_to_reg;
    logic                 branch;
    logic                 pcs;
    logic                 alu_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [1:0]           flag_w;
    logic [3:0]           cond;
  } de_t;

  typedef struct packed {
    logic reg_w;
    logic mem_w;
    logic mem_to_reg;
    logic pcs;
  } em_t;

  typedef struct packed {
    logic reg_w;
    logic mem_to_reg;
    logic pcs;
  } mw_t;

  de_t  dec, de_q;
  em_t  em_q;
  mw_t  mw_q;
  logic alu_op;
  logic cond_ex;

  // Decode: main decoder, ALU decoder and PC-source detection in one pass.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    dec     = '0;
    alu_op  = 1'b0;
    RegSrcD = 2'b00;
    ImmSrcD = 2'b00;
    case (OpD)
      2'b00: begin
        alu_op      = 1'b1;
        dec.alu_src = FunctD[5];
        dec.reg_w   = (FunctD[4:1] != 4'b1010);
      end
      2'b01: begin
        ImmSrcD     = 2'b01;
        dec.alu_src = 1'b1;
        if (FunctD[0]) begin
          dec.mem_to_reg = 1'b1;
          dec.reg_w      = 1'b1;
        end else begin
          RegSrcD   = 2'b10;
          dec.mem_w = 1'b1;
        end
      end
      2'b10: begin
        RegSrcD     = 2'b01;
        ImmSrcD     = 2'b10;
        dec.alu_src = 1'b1;
        dec.branch  = 1'b1;
      end
      default: ;
    endcase
    if (alu_op) begin
      case (FunctD[4:1])
        4'b0100: dec.alu_ctrl = ALUCTRL_W'(3'b000);
        4'b0010: dec.alu_ctrl = ALUCTRL_W'(3'b001);
        4'b0000: dec.alu_ctrl = ALUCTRL_W'(3'b010);
        4'b1100: dec.alu_ctrl = ALUCTRL_W'(3'b011);
        4'b1010: dec.alu_ctrl = ALUCTRL_W'(3'b001);
        4'b1101: dec.alu_ctrl = ALUCTRL_W'(3'b100);
        default: dec.alu_ctrl = ALUCTRL_W'(3'b000);
      endcase
      dec.flag_w[1] = FunctD[0];
      dec.flag_w[0] = FunctD[0] &
                      ((dec.alu_ctrl == ALUCTRL_W'(3'b000)) || (dec.alu_ctrl == ALUCTRL_W'(3'b001)));
    end
    dec.pcs  = dec.branch | (dec.reg_w & (RdD == {REG_ADDR_W{1'b1}}));
    dec.cond = CondD;
  end

  // A flushed slot is all zeros, so its Cond=EQ and it carries no write, branch or flag enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every pipeline register samples pre-edge values together.
    if (reset || FlushE) de_q <= '0;
    else                 de_q <= dec;
  end

`ifdef COND_LOGIC_EN
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: cond_holds = z;
      4'b0001: cond_holds = !z;
      4'b0010: cond_holds = c;
      4'b0011: cond_holds = !c;
      4'b0100: cond_holds = n;
      4'b0101: cond_holds = !n;
      4'b0110: cond_holds = v;
      4'b0111: cond_holds = !v;
      4'b1000: cond_holds = c & !z;
      4'b1001: cond_holds = !c | z;
      4'b1010: cond_holds = (n == v);
      4'b1011: cond_holds = (n != v);
      4'b1100: cond_holds = !z & (n == v);
      4'b1101: cond_holds = z | (n != v);
      4'b1110: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

  // Evaluated against flags left by older instructions; ALUFlagsE is deliberately not bypassed.
  assign cond_ex = cond_holds(de_q.cond, FlagsQ);
`else
  logic unused_cond;
  assign cond_ex     = 1'b1;
  assign unused_cond = ^de_q.cond;
`endif

  logic       reg_w_g, mem_w_g, pcs_g;
  logic [1:0] flag_w_g;

  assign reg_w_g  = de_q.reg_w & cond_ex;
  assign mem_w_g  = de_q.mem_w & cond_ex;
  assign pcs_g    = de_q.pcs   & cond_ex;
  assign flag_w_g = de_q.flag_w & {2{cond_ex}};

  always_ff @(posedge clk) begin
    if (reset) begin
      FlagsQ <= 4'b0000;
    end else begin
      if (flag_w_g[1]) FlagsQ[3:2] <= ALUFlagsE[3:2];
      if (flag_w_g[0]) FlagsQ[1:0] <= ALUFlagsE[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      em_q <= '0;
      mw_q <= '0;
    end else begin
      em_q <= '{reg_w: reg_w_g, mem_w: mem_w_g, mem_to_reg: de_q.mem_to_reg, pcs: pcs_g};
      mw_q <= '{reg_w: em_q.reg_w, mem_to_reg: em_q.mem_to_reg, pcs: em_q.pcs};
    end
  end

  assign ALUSrcE      = de_q.alu_src;
  assign ALUControlE  = de_q.alu_ctrl;
  assign BranchTakenE = de_q.branch & cond_ex;
  assign MemtoRegE    = de_q.mem_to_reg;
  assign RegWriteM    = em_q.reg_w;
  assign MemWriteM    = em_q.mem_w;
  assign MemtoRegW    = mw_q.mem_to_reg;
  assign RegWriteW    = mw_q.reg_w;
  assign PCSrcW       = mw_q.pcs;

endmodule
